// File: rtl/serial_magnitude_comparator_if.sv
// Operand/result handshake bundle for serial_magnitude_comparator.
// The master offers operands and consumes results; the slave is the comparator.
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = $clog2(NCH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             is_signed;
  logic             out_valid;
  logic             out_ready;
  logic             result;
  logic             out_err;
  logic [CW-1:0]    out_cycles;

  modport master (
    output in_valid, a, b, op, is_signed, out_ready,
    input  in_ready, out_valid, result, out_err, out_cycles
  );

  modport slave (
    input  in_valid, a, b, op, is_signed, out_ready,
    output in_ready, out_valid, result, out_err, out_cycles
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator: scans operands CHUNK bits per cycle, MSB first,
// and reports whether (a op b) holds, signed or unsigned.
module serial_magnitude_comparator #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  serial_magnitude_comparator_if.slave  bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = $clog2(NCH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {REL_EQ, REL_LT, REL_GT} rel_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_p0, b_p0;
  logic [2:0]       op_p0;
  rel_t             rel_p0, rel_d;
  logic [CW-1:0]    idx_p0;
  logic [CHUNK-1:0] ca, cb;
  logic [WIDTH-1:0] sflip;
  logic             accept, last, res_d, err_d;
  logic             result_q, err_q;
  logic [CW-1:0]    cyc_q;

  function automatic rel_t chunk_rel(input logic [CHUNK-1:0] x, input logic [CHUNK-1:0] y);
    if (x < y) return REL_LT;
    if (x > y) return REL_GT;
    return REL_EQ;
  endfunction

  // Returns {err, result}; reserved opcodes report an error with result 0.
  function automatic logic [1:0] eval_op(input rel_t r, input logic [2:0] op);
    case (op)
      3'd0:    return {1'b0, r == REL_EQ};
      3'd1:    return {1'b0, r != REL_EQ};
      3'd2:    return {1'b0, r == REL_LT};
      3'd3:    return {1'b0, r != REL_GT};
      3'd4:    return {1'b0, r == REL_GT};
      3'd5:    return {1'b0, r != REL_LT};
      default: return 2'b10;
    endcase
  endfunction

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign sflip  = {bus.is_signed, {(WIDTH-1){1'b0}}};
  assign accept = bus.in_valid && (state_q == IDLE);
  assign ca     = a_p0[WIDTH-1 -: CHUNK];
  assign cb     = b_p0[WIDTH-1 -: CHUNK];

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.result     = result_q;
  assign bus.out_err    = err_q;
  assign bus.out_cycles = cyc_q;

  always_comb begin
    state_d        = state_q;
    rel_d          = (rel_p0 == REL_EQ) ? chunk_rel(ca, cb) : rel_p0;
    last           = (idx_p0 == LAST_IDX) || ((EARLY_EXIT != 0) && (rel_d != REL_EQ));
    {err_d, res_d} = eval_op(rel_d, op_p0);
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (last) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= 1'b0;
      err_q    <= 1'b0;
      cyc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == BUSY && last) begin
        result_q <= res_d;
        err_q    <= err_d;
        cyc_q    <= idx_p0 + CW'(1);
      end
    end
  end

  // p0: latched operands shift left so the chunk under test is always at the top.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0   <= bus.a ^ sflip;
      b_p0   <= bus.b ^ sflip;
      op_p0  <= bus.op;
      rel_p0 <= REL_EQ;
      idx_p0 <= '0;
    end else if (state_q == BUSY) begin
      a_p0   <= a_p0 << CHUNK;
      b_p0   <= b_p0 << CHUNK;
      rel_p0 <= rel_d;
      idx_p0 <= idx_p0 + CW'(1);
    end
  end
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: directed cases on a 32/4 early-exit instance,
// plus random regression across CHUNK {1,4,8,32} x EARLY_EXIT {0,1}.
module tb_serial_magnitude_comparator;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference relation computed with plain 64-bit arithmetic.
  function automatic bit ref_res(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] op, input bit sg);
    longint sa, sb;
    sa = sg ? longint'($signed(a)) : longint'(a);
    sb = sg ? longint'($signed(b)) : longint'(b);
    case (op)
      3'd0:    return sa == sb;
      3'd1:    return sa != sb;
      3'd2:    return sa <  sb;
      3'd3:    return sa <= sb;
      3'd4:    return sa >  sb;
      3'd5:    return sa >= sb;
      default: return 1'b0;
    endcase
  endfunction

  // Cycles = position of the chunk holding the highest differing bit, or all chunks.
  function automatic int ref_cyc(input logic [31:0] a, input logic [31:0] b,
                                 input int chunk, input int ee);
    logic [31:0] x;
    int msb;
    x = a ^ b;
    msb = -1;
    if (ee == 0 || x == 0) return 32 / chunk;
    for (int i = 0; i < 32; i++) if (x[i]) msb = i;
    return (31 - msb) / chunk + 1;
  endfunction

  // ---------------- directed instance ----------------
  serial_magnitude_comparator_if #(.WIDTH(32), .CHUNK(4)) m_if ();
  serial_magnitude_comparator #(.WIDTH(32), .CHUNK(4), .EARLY_EXIT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (m_if)
  );

  task automatic m_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input bit sg, output bit res, output bit err, output int cyc);
    int n, lat;
    @(negedge clk);
    m_if.a = a; m_if.b = b; m_if.op = op; m_if.is_signed = sg; m_if.in_valid = 1'b1;
    n = 0;
    while (!m_if.in_ready && n < 50) begin @(negedge clk); n++; end
    if (!m_if.in_ready) check_eq("m_in_ready_wait", 0, 1);
    @(negedge clk);
    m_if.in_valid = 1'b0;
    lat = 0;
    while (!m_if.out_valid && lat < 64) begin lat++; @(negedge clk); end
    res = m_if.result;
    err = m_if.out_err;
    cyc = int'(m_if.out_cycles);
    check_eq("m_latency", lat, cyc);
    m_if.out_ready = 1'b1;
    @(negedge clk);
    m_if.out_ready = 1'b0;
    check_eq("m_idle_after_handshake", m_if.in_ready, 1);
  endtask

  initial begin
    bit res, err;
    int cyc, n, seen;
    m_if.in_valid = 0; m_if.a = 0; m_if.b = 0; m_if.op = 0; m_if.is_signed = 0;
    m_if.out_ready = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", m_if.out_valid, 0);
    check_eq("rst_result", m_if.result, 0);
    check_eq("rst_out_err", m_if.out_err, 0);
    check_eq("rst_out_cycles", m_if.out_cycles, 0);
    check_eq("rst_in_ready", m_if.in_ready, 1);
    rst = 1'b0;

    m_op(32'hFFFFFFFF, 32'h0, 3'd3, 1'b1, res, err, cyc);
    check_eq("le_signed_res", res, 1);
    check_eq("le_signed_cyc", cyc, 1);
    m_op(32'hFFFFFFFF, 32'h0, 3'd3, 1'b0, res, err, cyc);
    check_eq("le_unsigned_res", res, 0);
    m_op(32'h12345678, 32'h12345678, 3'd0, 1'b0, res, err, cyc);
    check_eq("eq_res", res, 1);
    check_eq("eq_cyc", cyc, 8);
    check_eq("eq_err", err, 0);
    m_op(32'h12345678, 32'h12345678, 3'd1, 1'b0, res, err, cyc);
    check_eq("ne_res", res, 0);
    m_op(32'h1, 32'h2, 3'd2, 1'b0, res, err, cyc);
    check_eq("lt_small_res", res, 1);
    check_eq("lt_small_cyc", cyc, 8);
    m_op(32'h80000000, 32'h7FFFFFFF, 3'd2, 1'b1, res, err, cyc);
    check_eq("min_lt_max_signed", res, 1);
    m_op(32'h80000000, 32'h7FFFFFFF, 3'd4, 1'b1, res, err, cyc);
    check_eq("min_gt_max_signed", res, 0);
    m_op(32'h80000000, 32'h7FFFFFFF, 3'd4, 1'b0, res, err, cyc);
    check_eq("min_gt_max_unsigned", res, 1);
    m_op(32'hFFFFFFFF, 32'h0, 3'd2, 1'b1, res, err, cyc);
    check_eq("neg1_lt_zero", res, 1);

    // Output held while consumer stalls; new operands must be ignored.
    @(negedge clk);
    m_if.a = 32'd5; m_if.b = 32'd3; m_if.op = 3'd4; m_if.is_signed = 0; m_if.in_valid = 1;
    @(negedge clk);
    m_if.in_valid = 0;
    n = 0;
    while (!m_if.out_valid && n < 64) begin n++; @(negedge clk); end
    m_if.in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      m_if.a = $urandom; m_if.b = $urandom; m_if.op = 3'($urandom_range(0, 7));
      @(negedge clk);
      check_eq("stall_out_valid", m_if.out_valid, 1);
      check_eq("stall_result", m_if.result, 1);
      check_eq("stall_cycles", m_if.out_cycles, 8);
      check_eq("stall_in_ready", m_if.in_ready, 0);
    end
    m_if.in_valid = 0;
    m_if.out_ready = 1;
    @(negedge clk);
    m_if.out_ready = 0;
    check_eq("stall_release_valid", m_if.out_valid, 0);
    check_eq("stall_release_ready", m_if.in_ready, 1);
    @(negedge clk);
    check_eq("stall_no_accept", m_if.in_ready, 1);

    // Reset during the third BUSY cycle discards the operation.
    @(negedge clk);
    m_if.a = 32'h12345678; m_if.b = 32'h12345678; m_if.op = 3'd0; m_if.in_valid = 1;
    @(negedge clk);
    m_if.in_valid = 0;
    repeat (2) @(negedge clk);
    check_eq("busy_before_rst", m_if.in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_out_valid", m_if.out_valid, 0);
    check_eq("midrst_in_ready", m_if.in_ready, 1);
    seen = 0;
    repeat (12) begin @(negedge clk); if (m_if.out_valid) seen++; end
    check_eq("midrst_no_result", seen, 0);
    m_op(32'h1, 32'h2, 3'd6, 1'b0, res, err, cyc);
    check_eq("op6_res", res, 0);
    check_eq("op6_err", err, 1);
    m_op(32'h1, 32'h1, 3'd7, 1'b1, res, err, cyc);
    check_eq("op7_res", res, 0);
    check_eq("op7_err", err, 1);

    n = 0;
    while (n_done < 8 && n < 90000) begin @(negedge clk); n++; end
    check_eq("regression_done", n_done, 8);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- random regression instances ----------------
  genvar g;
  generate
    for (g = 0; g < 8; g++) begin : cfg
      localparam int CH = (g / 2 == 0) ? 1 : (g / 2 == 1) ? 4 : (g / 2 == 2) ? 8 : 32;
      localparam int EE = g % 2;
      logic rst_g;
      serial_magnitude_comparator_if #(.WIDTH(32), .CHUNK(CH)) ifc ();
      serial_magnitude_comparator #(.WIDTH(32), .CHUNK(CH), .EARLY_EXIT(EE)) dut_r (
        .clk (clk),
        .rst (rst_g),
        .bus (ifc)
      );

      initial begin
        logic [31:0] a, b;
        logic [31:0] ext [6];
        logic [2:0]  op;
        bit          sg, r;
        int          n, lat, m, ecyc;
        string       pfx;
        ext[0] = 32'h0; ext[1] = 32'h1; ext[2] = 32'h7FFFFFFF;
        ext[3] = 32'h80000000; ext[4] = 32'hFFFFFFFF; ext[5] = 32'h80000001;
        pfx = $sformatf("c%0d_e%0d", CH, EE);
        ifc.in_valid = 0; ifc.a = 0; ifc.b = 0; ifc.op = 0; ifc.is_signed = 0;
        ifc.out_ready = 0;
        rst_g = 1'b1;
        repeat (2) @(negedge clk);
        rst_g = 1'b0;
        for (int t = 0; t < 1250; t++) begin
          m = $urandom_range(0, 3);
          a = $urandom; b = $urandom;
          op = 3'($urandom_range(0, 7));
          sg = 1'($urandom_range(0, 1));
          if (m == 1) b = a;
          else if (m == 2) b = a ^ (32'h1 << $urandom_range(0, 31));
          else if (m == 3) begin
            a = ext[$urandom_range(0, 5)];
            b = ext[$urandom_range(0, 5)];
          end
          if (t == 0) begin a = 32'hFFFFFFFF; b = 32'h0; op = 3'd3; sg = 1; end
          if (t == 1) begin a = 32'hFFFFFFFF; b = 32'h0; op = 3'd3; sg = 0; end
          if (t == 2) begin a = 32'h12345678; b = 32'h12345678; op = 3'd0; end
          if (t == 3) begin a = 32'h80000000; b = 32'h7FFFFFFF; op = 3'd2; sg = 1; end
          @(negedge clk);
          ifc.a = a; ifc.b = b; ifc.op = op; ifc.is_signed = sg; ifc.in_valid = 1;
          n = 0;
          while (!ifc.in_ready && n < 50) begin @(negedge clk); n++; end
          @(negedge clk);
          ifc.in_valid = 0;
          lat = 0;
          while (!ifc.out_valid && lat < 40) begin lat++; @(negedge clk); end
          ecyc = ref_cyc(a, b, CH, EE);
          check_eq({pfx, "_result"}, ifc.result, ref_res(a, b, op, sg));
          check_eq({pfx, "_err"}, ifc.out_err, (op >= 3'd6) ? 1 : 0);
          check_eq({pfx, "_cycles"}, ifc.out_cycles, ecyc);
          check_eq({pfx, "_latency"}, lat, ecyc);
          do begin
            r = 1'($urandom_range(0, 1));
            ifc.out_ready = r;
            @(negedge clk);
          end while (!r);
          ifc.out_ready = 0;
        end
        n_done++;
      end
    end
  endgenerate
endmodule

// File: doc/serial_magnitude_comparator.md
SERIAL_MAGNITUDE_COMPARATOR -- requirements
Module: serial_magnitude_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand width in bits; legal when WIDTH >= 2.
REQ-002 SHALL have parameter CHUNK, default 4: bits compared per cycle; legal when 1 <= CHUNK <= WIDTH and WIDTH % CHUNK == 0; NCH = WIDTH/CHUNK.
REQ-003 SHALL have parameter EARLY_EXIT, default 1: 1 = finish at first differing chunk, 0 = always scan all NCH chunks.
REQ-004 SHALL have one clock and one reset: reset is synchronous and active-high; ports are clk and rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  operand set offered.
REQ-008 in_ready  output  1  block can accept operands.
REQ-009 a  input  WIDTH  left operand.
REQ-010 b  input  WIDTH  right operand.
REQ-011 op  input  3  relation: 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6/7 reserved.
REQ-012 is_signed  input  1  1 = two's-complement compare, 0 = unsigned.
REQ-013 out_valid  output  1  result available.
REQ-014 out_ready  input  1  consumer takes result.
REQ-015 result  output  1  value of (a op b).
REQ-016 out_err  output  1  latched op was reserved.
REQ-017 out_cycles  output  clog2(NCH+1)  number of BUSY cycles spent on this result.

Function
REQ-018 SHALL implement states IDLE, BUSY, DONE; in_ready = 1 only in IDLE (decoded from state, no combinational path from inputs).
REQ-019 SHALL accept on in_valid && in_ready at a rising edge: latch a, b, op, is_signed; if is_signed, invert bit WIDTH-1 of both latched operands; clear relation to EQ, chunk index to 0, cycle count to 0; go to BUSY.
REQ-020 SHALL ignore a, b, op, is_signed, in_valid outside the accepting edge.
REQ-021 SHALL, per BUSY cycle, compare chunk idx taken MSB-first (bits WIDTH-1-idx*CHUNK down to WIDTH-(idx+1)*CHUNK) as unsigned; if relation is EQ it becomes LT/EQ/GT of that chunk, otherwise unchanged; idx and cycle count increment.
REQ-022 SHALL leave BUSY for DONE after the cycle processing idx = NCH-1, or, when EARLY_EXIT = 1, after the first cycle whose relation becomes non-EQ.
REQ-023 SHALL register result, out_err, out_cycles on the BUSY->DONE edge: result = relation satisfies op; op 6/7 give result 0, out_err 1; otherwise out_err 0.
REQ-024 SHALL assert out_valid only in DONE and hold result, out_err, out_cycles stable until out_valid && out_ready at a rising edge, then return to IDLE.
REQ-025 Latency: operands accepted at edge k give out_valid from edge k+out_cycles; out_cycles = NCH when EARLY_EXIT = 0 or operands equal; minimum 1.
REQ-026 Throughput: next acceptance no earlier than the edge after the output handshake; no overlap of operations.
REQ-027 SHALL give identical result for any CHUNK and EARLY_EXIT setting; only out_cycles differs.
REQ-028 SHALL treat signed extremes exactly: most negative value is below every other value; -1 below 0.

Reset
REQ-029 SHALL, on rst high at a rising edge, enter IDLE and set out_valid 0, result 0, out_err 0, out_cycles 0 regardless of current state; in_ready is 1 the cycle after.
REQ-030 SHALL discard any operation in progress at reset with no result emitted; rst has priority over in_valid and out_ready on the same edge.

Verification (WIDTH=32, CHUNK=4 unless stated)
REQ-031 a=0xFFFFFFFF, b=0x00000000, op=LE: is_signed=1 -> result 1, out_cycles 1 (EARLY_EXIT=1) or 8 (EARLY_EXIT=0); is_signed=0 -> result 0.
REQ-032 a=b=0x12345678, op=EQ -> result 1, out_cycles 8; op=NE -> result 0; a=0x00000001, b=0x00000002, op=LT -> result 1, out_cycles 8.
REQ-033 a=0x80000000, b=0x7FFFFFFF, is_signed=1: op=LT -> 1, op=GT -> 0; is_signed=0: op=GT -> 1.
REQ-034 out_ready held 0 for 5 cycles in DONE with in_valid=1 and changing a/b -> out_valid, result, out_cycles stable, in_ready 0, no new acceptance; out_ready=1 -> IDLE next cycle.
REQ-035 rst asserted during BUSY (cycle 3 of 8) -> next cycle out_valid 0, in_ready 1, no result for that operand set; op=6 then gives result 0, out_err 1.
REQ-036 Random regression, CHUNK in {1,4,8,32}, EARLY_EXIT in {0,1}, 10k operand sets with random out_ready -> every result matches the reference relation for op/is_signed.
